ring_port: RTL and testbench

RING_PORT -- requirements
Module: ring_port

---
 rtl/ring_port.sv | 97 +++++++++
 tb/tb_ring_port.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ring_port.sv
// Ring node port: ejects packets addressed to this node, forwards others, and
// injects local traffic into free ring slots, bouncing it back when the slot is busy.
module ring_port #(
    parameter int N    = 2,
    parameter int D_W  = 32,
    parameter int A_W  = $clog2(N) + 1,
    parameter int posx = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [A_W+D_W+1:0]     ring_in,
    output logic [A_W+D_W+1:0]     ring_out,
    input  logic [A_W+D_W+1:0]     i,
    output logic [A_W+D_W+1:0]     o,
    output logic [15:0]            eject_cnt,
    output logic [15:0]            bounce_cnt,
    output logic [15:0]            pass_cnt,
    output logic                   err
);

    localparam int W  = A_W + D_W + 2;
    localparam int VB = W - 1;
    localparam int DB = W - 2;
    localparam logic [A_W-1:0] POS   = A_W'(posx);
    localparam logic [A_W:0]   N_LIM = (A_W + 1)'(N);

    logic           ring_v, inj_v;
    logic [A_W-1:0] ring_a, inj_a;
    logic           hit, pass, inj_self;
    logic [W-1:0]   ring_out_n, o_n;
    logic           eject_inc, bounce_inc, pass_inc, err_set;

    assign ring_v = ring_in[VB];
    assign inj_v  = i[VB];
    assign ring_a = ring_in[A_W+D_W-1:D_W];
    assign inj_a  = i[A_W+D_W-1:D_W];

    always_comb begin
        ring_out_n = '0;
        o_n        = '0;
        eject_inc  = 1'b0;
        bounce_inc = 1'b0;
        pass_inc   = 1'b0;

        hit      = ring_v && (ring_a == POS);
        pass     = ring_v && (ring_a != POS);
        inj_self = inj_v && (inj_a == POS);

        if (pass) begin
            ring_out_n = ring_in;
            pass_inc   = 1'b1;
        end else if (inj_v && !inj_self) begin
            ring_out_n     = i;
            ring_out_n[DB] = 1'b0;
        end

        // o priority: ring eject, then local delivery, then bounce of a blocked
        // injection. A self-addressed injection losing o to a ring hit is left
        // for the client to retry.
        if (hit) begin
            o_n       = ring_in;
            o_n[DB]   = 1'b0;
            eject_inc = 1'b1;
        end else if (inj_self) begin
            o_n       = i;
            o_n[DB]   = 1'b0;
            eject_inc = 1'b1;
        end else if (inj_v && pass) begin
            o_n        = i;
            o_n[DB]    = 1'b1;
            bounce_inc = 1'b1;
        end

        err_set = (ring_v && ({1'b0, ring_a} >= N_LIM)) ||
                  (inj_v  && ({1'b0, inj_a}  >= N_LIM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_out   <= '0;
            o          <= '0;
            eject_cnt  <= '0;
            bounce_cnt <= '0;
            pass_cnt   <= '0;
            err        <= 1'b0;
        end else if (ce) begin
            ring_out <= ring_out_n;
            o        <= o_n;
            if (eject_inc  && eject_cnt  != '1) eject_cnt  <= eject_cnt + 16'd1;
            if (bounce_inc && bounce_cnt != '1) bounce_cnt <= bounce_cnt + 16'd1;
            if (pass_inc   && pass_cnt   != '1) pass_cnt   <= pass_cnt + 16'd1;
            if (err_set) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ring_port.sv
// Scoreboard bench for ring_port (N=4, D_W=32, A_W=3, posx=2): the driver queues
// hand-computed expectations, the monitor compares them one cycle later.
module tb_ring_port;

    localparam int N = 4, D_W = 32, A_W = 3, POSX = 2;
    localparam int W = A_W + D_W + 2;

    logic         clk = 1'b0;
    logic         rst, ce;
    logic [W-1:0] ring_in, i, ring_out, o;
    logic [15:0]  eject_cnt, bounce_cnt, pass_cnt;
    logic         err;

    typedef struct {
        string        name;
        logic [W-1:0] ro;
        logic [W-1:0] oo;
        logic [15:0]  ej;
        logic [15:0]  bo;
        logic [15:0]  pa;
        logic         er;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    ring_port #(.N(N), .D_W(D_W), .A_W(A_W), .posx(POSX)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .ring_in(ring_in), .ring_out(ring_out),
        .i(i), .o(o),
        .eject_cnt(eject_cnt), .bounce_cnt(bounce_cnt), .pass_cnt(pass_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic v, input logic d,
                                        input int a, input logic [31:0] data);
        logic [W-1:0] m;
        m = '0;
        m[W-1] = v;
        m[W-2] = d;
        m[A_W+D_W-1:D_W] = A_W'(a);
        m[D_W-1:0] = data;
        return m;
    endfunction

    task automatic chk(input string name, input string field,
                       input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", name, field, got, want);
        end
    endtask

    // Monitor: one cycle after each queued stimulus, compare the registered outputs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk(e.name, "ring_out",   ring_out,            e.ro);
                chk(e.name, "o",          o,                   e.oo);
                chk(e.name, "eject_cnt",  W'(eject_cnt),       W'(e.ej));
                chk(e.name, "bounce_cnt", W'(bounce_cnt),      W'(e.bo));
                chk(e.name, "pass_cnt",   W'(pass_cnt),        W'(e.pa));
                chk(e.name, "err",        W'(err),             W'(e.er));
            end
        end
    end

    task automatic drive(input logic r, input logic c,
                         input logic [W-1:0] rin, input logic [W-1:0] inj);
        @(negedge clk);
        rst = r; ce = c; ring_in = rin; i = inj;
    endtask

    task automatic step(input string name, input logic r, input logic c,
                        input logic [W-1:0] rin, input logic [W-1:0] inj,
                        input logic [W-1:0] ro, input logic [W-1:0] oo,
                        input int ej, input int bo, input int pa, input logic er);
        exp_t e;
        drive(r, c, rin, inj);
        e.name = name; e.ro = ro; e.oo = oo;
        e.ej = 16'(ej); e.bo = 16'(bo); e.pa = 16'(pa); e.er = er;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; ring_in = '0; i = '0;
        repeat (2) @(negedge clk);

        // Reset wins even with ce low and valid inputs present.
        step("reset",      1, 0, mk(1,0,2,32'h1), mk(1,0,3,32'h2), '0, '0, 0,0,0, 0);
        step("eject",      0, 1, mk(1,1,2,32'h55), '0,
             '0, mk(1,0,2,32'h55), 1,0,0, 0);
        step("pass_inj",   0, 1, mk(1,0,3,32'h7), mk(1,0,0,32'h9),
             mk(1,0,3,32'h7), mk(1,1,0,32'h9), 1,1,1, 0);
        step("eject_inj",  0, 1, mk(1,0,2,32'h1), mk(1,0,1,32'h4),
             mk(1,0,1,32'h4), mk(1,0,2,32'h1), 2,1,1, 0);
        step("self_idle",  0, 1, '0, mk(1,0,2,32'h8),
             '0, mk(1,0,2,32'h8), 3,1,1, 0);
        step("self_hit",   0, 1, mk(1,0,2,32'hA), mk(1,1,2,32'hB),
             '0, mk(1,0,2,32'hA), 4,1,1, 0);
        step("inj_idle",   0, 1, '0, mk(1,1,3,32'hC),
             mk(1,0,3,32'hC), '0, 4,1,1, 0);
        step("pass_self",  0, 1, mk(1,1,0,32'hD), mk(1,0,2,32'hE),
             mk(1,1,0,32'hD), mk(1,0,2,32'hE), 5,1,2, 0);
        for (int k = 0; k < 3; k++)
            step("ce_low", 0, 0, mk(1,0,2,32'hF0 + k), mk(1,0,2,32'h1),
                 mk(1,1,0,32'hD), mk(1,0,2,32'hE), 5,1,2, 0);
        step("idle",       0, 1, '0, '0, '0, '0, 5,1,2, 0);
        step("err_ring",   0, 1, mk(1,0,5,32'h1), '0,
             mk(1,0,5,32'h1), '0, 5,1,3, 1);
        step("err_sticky", 0, 1, '0, '0, '0, '0, 5,1,3, 1);

        // 65540 passes starting from pass_cnt=3: hits 65535 at pass 65532, then holds.
        for (int n = 1; n <= 65540; n++) begin
            if (n == 65532)
                step("sat_reach", 0, 1, mk(1,0,1,32'(n)), '0,
                     mk(1,0,1,32'(n)), '0, 5,1,65535, 1);
            else if (n == 65540)
                step("sat_hold", 0, 1, mk(1,0,1,32'(n)), '0,
                     mk(1,0,1,32'(n)), '0, 5,1,65535, 1);
            else
                drive(0, 1, mk(1,0,1,32'(n)), '0);
        end

        step("rst_mid",    1, 1, mk(1,0,3,32'h5), mk(1,0,0,32'h6), '0, '0, 0,0,0, 0);
        step("post_rst",   0, 1, mk(1,0,2,32'h77), '0,
             '0, mk(1,0,2,32'h77), 1,0,0, 0);
        step("err_inj",    0, 1, '0, mk(1,1,6,32'h3),
             mk(1,0,6,32'h3), '0, 1,0,0, 1);
        drive(0, 1, '0, '0);

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
